// File: rtl/player_pkg.sv
// Shared types and key codes for the player motion block.
package player_pkg;

    typedef enum logic [1:0] {
        GROUNDED = 2'd0,
        RISE     = 2'd1,
        FALL     = 2'd2
    } motion_state_t;

    typedef logic signed [7:0] vel_t;

    localparam logic [7:0] KEY_LEFT  = 8'd4;
    localparam logic [7:0] KEY_RIGHT = 8'd7;
    localparam logic [7:0] KEY_JUMP  = 8'd26;

endpackage

// File: rtl/player_motion_key_edge.sv
// Rising-edge pulse for one keycode, relative to the keycode seen last frame.
module key_edge_detect #(
    parameter logic [7:0] KEY = 8'd26
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    output logic       key_edge
);

    logic [7:0] prev_key;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) prev_key <= '0;
        else       prev_key <= keycode;
    end

    assign key_edge = (keycode == KEY) && (prev_key != KEY);

endmodule

// File: rtl/player_motion.sv
// Per-frame player kinematics: walk, jump, gravity, floor/ceiling, edge clamp.
// Optional air jump enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion
    import player_pkg::*;
#(
    parameter int POS_W     = 10,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 639,
    parameter int Y_MIN     = 0,
    parameter int FLOOR_Y   = 400,
    parameter int SIZE      = 4,
    parameter int X_START   = 320,
    parameter int WALK_STEP = 3,
    parameter int JUMP_VEL  = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 10
) (
    input  logic              frame_clk,
    input  logic              Reset,
    input  logic [7:0]        keycode,
    output logic [POS_W-1:0]  PosX,
    output logic [POS_W-1:0]  PosY,
    output logic [POS_W-1:0]  Size,
    output vel_t              VelY,
    output motion_state_t     State,
    output logic              Facing
);

    localparam int SW = POS_W + 2;
    typedef logic signed [SW-1:0] spos_t;

    localparam spos_t X_LO   = spos_t'(X_MIN + SIZE);
    localparam spos_t X_HI   = spos_t'(X_MAX - SIZE);
    localparam spos_t Y_REST = spos_t'(FLOOR_Y - SIZE);
    localparam spos_t Y_CEIL = spos_t'(Y_MIN + SIZE);

    function automatic logic [POS_W-1:0] to_pos(input spos_t v);
        return v[POS_W-1:0];
    endfunction

    logic jump_edge;

    key_edge_detect #(.KEY(KEY_JUMP)) u_jump_edge (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .keycode   (keycode),
        .key_edge  (jump_edge)
    );

    spos_t             x_step, x_clamp, y_sum;
    logic              facing_next;
    logic signed [8:0] vel_sum;
    vel_t              vel_grav;

    always_comb begin
        x_step      = $signed({2'b00, PosX});
        facing_next = Facing;
        if (keycode == KEY_LEFT) begin
            x_step      = $signed({2'b00, PosX}) - spos_t'(WALK_STEP);
            facing_next = 1'b0;
        end else if (keycode == KEY_RIGHT) begin
            x_step      = $signed({2'b00, PosX}) + spos_t'(WALK_STEP);
            facing_next = 1'b1;
        end
        // Clamp in the widened signed domain so stepping left of 0 cannot wrap.
        x_clamp = x_step;
        if (x_step < X_LO) x_clamp = X_LO;
        if (x_step > X_HI) x_clamp = X_HI;

        y_sum    = $signed({2'b00, PosY}) + spos_t'(VelY);
        vel_sum  = 9'(VelY) + 9'(GRAVITY);
        vel_grav = (vel_sum > 9'(MAX_FALL)) ? vel_t'(MAX_FALL) : vel_t'(vel_sum[7:0]);
    end

`ifdef PLAYER_DOUBLE_JUMP_EN
    logic air_jump_used;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            PosX   <= POS_W'(X_START);
            PosY   <= to_pos(Y_REST);
            VelY   <= '0;
            State  <= GROUNDED;
            Facing <= 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_jump_used <= 1'b0;
`endif
        end else begin
            PosX   <= to_pos(x_clamp);
            Facing <= facing_next;
            case (State)
                GROUNDED: begin
                    VelY <= '0;
                    if (jump_edge) begin
                        VelY  <= vel_t'(-JUMP_VEL);
                        State <= RISE;
                    end
                end
                RISE, FALL: begin
                    // Landing wins over any jump edge arriving in the same frame.
                    if (y_sum >= Y_REST) begin
                        PosY  <= to_pos(Y_REST);
                        VelY  <= '0;
                        State <= GROUNDED;
`ifdef PLAYER_DOUBLE_JUMP_EN
                        air_jump_used <= 1'b0;
`endif
                    end else begin
                        PosY <= (y_sum < Y_CEIL) ? to_pos(Y_CEIL) : to_pos(y_sum);
`ifdef PLAYER_DOUBLE_JUMP_EN
                        if (jump_edge && !air_jump_used) begin
                            VelY          <= vel_t'(-JUMP_VEL);
                            State         <= RISE;
                            air_jump_used <= 1'b1;
                        end else
`endif
                        if (y_sum < Y_CEIL) begin
                            VelY  <= '0;
                            State <= FALL;
                        end else begin
                            VelY  <= vel_grav;
                            State <= vel_grav[7] ? RISE : FALL;
                        end
                    end
                end
                default: State <= GROUNDED;
            endcase
        end
    end

    assign Size = POS_W'(SIZE);

endmodule
